finite_pred_stream: RTL and testbench

//  Sequential counterpart of the Finite-N successor datapath: emits a stream of

---
 rtl/finite_pred_stream.sv | 87 ++++++++
 tb/tb_finite_pred_stream.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/finite_pred_stream.sv
// Streams predecessors (x-1 mod N) from a loaded start value, one per accepted
// output handshake, for a loaded number of steps; wraps from 0 to N-1.
module finite_pred_stream #(
  parameter int N  = 100,
  parameter int W  = $clog2(N),
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [W-1:0]  ld_value,
  input  logic [LW-1:0] ld_len,
  output logic          ld_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          wrap,
  output logic          done
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and out_data is frozen while stalled.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   count, count_next;
  logic [LW-1:0]  remain, remain_next;
  logic           wrap_next, done_next;
  logic           ld_fire, out_fire;

  assign ld_ready  = (state == IDLE);
  assign out_valid = (state == RUN);
  assign out_data  = count;
  assign ld_fire   = ld_valid & ld_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_next  = state;
    count_next  = count;
    remain_next = remain;
    wrap_next   = 1'b0;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (ld_fire) begin
          // Oversized start values fold into [0, N-1] so count < N always holds.
          count_next  = W'(ld_value % W'(N));
          remain_next = ld_len;
          if (ld_len != '0) state_next = RUN;
          else              done_next  = 1'b1;
        end
      end
      RUN: begin
        if (out_fire) begin
          count_next  = (count == '0) ? W'(N - 1) : count - W'(1);
          remain_next = remain - LW'(1);
          wrap_next   = (count == '0);
          if (remain == LW'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      remain <= '0;
      wrap   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      remain <= remain_next;
      wrap   <= wrap_next;
      done   <= done_next;
    end
  end

endmodule

// File: tb/tb_finite_pred_stream.sv
// Directed bench for finite_pred_stream: hand-computed predecessor sequences,
// wrap/done pulses, stalls, zero-length loads and mid-sequence reset.
module tb_finite_pred_stream;

  localparam int N  = 100;
  localparam int W  = 7;
  localparam int LW = 8;

  logic          clk;
  logic          rst;
  logic          ld_valid;
  logic [W-1:0]  ld_value;
  logic [LW-1:0] ld_len;
  logic          ld_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          wrap;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  finite_pred_stream #(.N(N), .W(W), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_value  (ld_value),
    .ld_len    (ld_len),
    .ld_ready  (ld_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .wrap      (wrap),
    .done      (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after a rising edge, outputs are
  // sampled at that same point, well away from the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int value, input int len);
    ld_valid = 1'b1;
    ld_value = W'(value);
    ld_len   = LW'(len);
    step();
    ld_valid = 1'b0;
  endtask

  // Flags are checked together as {out_valid, ld_ready, wrap, done}.
  task automatic test_reset();
    rst       = 1'b0;
    ld_valid  = 1'b0;
    ld_value  = '0;
    ld_len    = '0;
    out_ready = 1'b0;
    step();
    step();
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0100", {out_valid, ld_ready, wrap, done});
    end
    n_checks++;
    if (out_data !== W'(0)) begin
      n_fail++;
      $display("FAIL reset_data: got %0d expected 0", out_data);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_wrap_sequence();
    int exp_v[7] = '{5, 4, 3, 2, 1, 0, 99};
    out_ready = 1'b1;
    load(5, 7);
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (out_data !== W'(exp_v[i])) begin
        n_fail++;
        $display("FAIL seq1_data[%0d]: got %0d expected %0d", i, out_data, exp_v[i]);
      end
      n_checks++;
      if ({out_valid, ld_ready, wrap, done} !== {3'b100, 1'b0} + {2'b00, (i == 6), 1'b0}) begin
        n_fail++;
        $display("FAIL seq1_flags[%0d]: got %b expected %b", i,
                 {out_valid, ld_ready, wrap, done}, {2'b10, (i == 6), 1'b0});
      end
      step();
    end
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0101) begin
      n_fail++;
      $display("FAIL seq1_done: got %b expected 0101", {out_valid, ld_ready, wrap, done});
    end
    step();
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL seq1_idle: got %b expected 0100", {out_valid, ld_ready, wrap, done});
    end
  endtask

  task automatic test_fold_load();
    int exp_v[2] = '{27, 26};
    out_ready = 1'b1;
    load(127, 2);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (!out_valid || out_data !== W'(exp_v[i])) begin
        n_fail++;
        $display("FAIL fold_data[%0d]: got valid=%b data=%0d expected valid=1 data=%0d",
                 i, out_valid, out_data, exp_v[i]);
      end
      step();
    end
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0101) begin
      n_fail++;
      $display("FAIL fold_done: got %b expected 0101", {out_valid, ld_ready, wrap, done});
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    load(42, 3);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (!out_valid || out_data !== W'(42) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%0d done=%b expected valid=1 data=42 done=0",
                 i, out_valid, out_data, done);
      end
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!out_valid || out_data !== W'(42 - i)) begin
        n_fail++;
        $display("FAIL stall_release[%0d]: got valid=%b data=%0d expected valid=1 data=%0d",
                 i, out_valid, out_data, 42 - i);
      end
      step();
    end
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0101) begin
      n_fail++;
      $display("FAIL stall_done: got %b expected 0101", {out_valid, ld_ready, wrap, done});
    end
  endtask

  task automatic test_single_zero();
    out_ready = 1'b1;
    load(0, 1);
    n_checks++;
    if (!out_valid || out_data !== W'(0)) begin
      n_fail++;
      $display("FAIL zero_data: got valid=%b data=%0d expected valid=1 data=0", out_valid, out_data);
    end
    step();
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0111) begin
      n_fail++;
      $display("FAIL zero_pulses: got %b expected 0111", {out_valid, ld_ready, wrap, done});
    end
    n_checks++;
    if (out_data !== W'(99)) begin
      n_fail++;
      $display("FAIL zero_final_count: got %0d expected 99", out_data);
    end
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1;
    load(9, 0);
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0101) begin
      n_fail++;
      $display("FAIL len0_done: got %b expected 0101", {out_valid, ld_ready, wrap, done});
    end
    step();
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL len0_after: got %b expected 0100", {out_valid, ld_ready, wrap, done});
    end
  endtask

  task automatic test_reset_mid_run();
    out_ready = 1'b1;
    load(10, 8);
    step();
    // Load attempt while running must be ignored.
    ld_valid = 1'b1;
    ld_value = W'(50);
    ld_len   = LW'(3);
    n_checks++;
    if (ld_ready !== 1'b0 || out_data !== W'(9)) begin
      n_fail++;
      $display("FAIL run_ld_ready: got ld_ready=%b data=%0d expected ld_ready=0 data=9", ld_ready, out_data);
    end
    step();
    ld_valid = 1'b0;
    n_checks++;
    if (!out_valid || out_data !== W'(8)) begin
      n_fail++;
      $display("FAIL run_ld_ignored: got valid=%b data=%0d expected valid=1 data=8", out_valid, out_data);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0100 || out_data !== W'(0)) begin
      n_fail++;
      $display("FAIL midrst_state: got flags=%b data=%0d expected flags=0100 data=0",
               {out_valid, ld_ready, wrap, done}, out_data);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({out_valid, ld_ready, wrap, done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %b expected 0100", {out_valid, ld_ready, wrap, done});
    end
  endtask

  initial begin
    test_reset();
    test_wrap_sequence();
    test_fold_load();
    test_stall();
    test_single_zero();
    test_zero_len();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
